bistable_event_decoder: RTL
===========================

BISTABLE_EVENT_DECODER -- requirements
Module: bistable_event_decoder

Interface
REQ-001 Parameter WIDTH, default 2, SHALL set the number of independent level channels.
REQ-002 Parameter FILTER, default 3, SHALL set the consecutive-cycle count required to accept a level change; legal range 1..255.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst  input  1  SHALL be the synchronous, active-high reset.
REQ-005 in  input  WIDTH  SHALL carry level signals already synchronized into the clk domain, e.g. from the bistable domain-crossing block.
REQ-006 ack  input  WIDTH  SHALL be a per-channel acknowledge; 1 in a cycle clears that channel's pending and overflow flags.
REQ-007 out  output  WIDTH  SHALL be the filtered, accepted level per channel.
REQ-008 rise  output  WIDTH  SHALL be a one-cycle pulse per channel on an accepted 0->1 change.
REQ-009 fall  output  WIDTH  SHALL be a one-cycle pulse per channel on an accepted 1->0 change.
REQ-010 pend  output  WIDTH  SHALL be a sticky per-channel event-pending flag.
REQ-011 ovf  output  WIDTH  SHALL be a sticky per-channel flag: event lost while pending.
REQ-012 irq  output  1  SHALL equal the OR of all pend bits, registered-free (combinational from pend).

Function
REQ-013 Each channel SHALL own a counter cnt, width clog2(FILTER+1), counting consecutive sampled cycles with in != out.
REQ-014 Edge with in == out: cnt SHALL clear to 0, out unchanged, no pulse.
REQ-015 Edge with in != out and cnt < FILTER-1: cnt SHALL increment, out unchanged.
REQ-016 Edge with in != out and cnt == FILTER-1: out SHALL take in, cnt SHALL clear, and rise or fall SHALL be 1 for the following cycle only.
REQ-017 Acceptance latency SHALL be exactly FILTER edges after in first differs from out; FILTER=1 gives out one cycle after in changes.
REQ-018 A glitch of fewer than FILTER consecutive cycles SHALL produce no change on out, rise, fall, pend or ovf.
REQ-019 rise and fall SHALL be registered, never both 1 for one channel, and 0 in every cycle without acceptance.
REQ-020 Acceptance edge SHALL set pend; ack alone SHALL clear pend and ovf on that edge.
REQ-021 Acceptance and ack on the same edge: pend SHALL remain 1, ovf SHALL clear (set wins over clear for pend).
REQ-022 Acceptance while pend==1 and ack==0: ovf SHALL set; pend stays 1.
REQ-023 ack to a channel with pend==0 SHALL have no effect besides clearing ovf.
REQ-024 Channels SHALL be fully independent; simultaneous acceptances on several channels SHALL all be reported in the same cycle.
REQ-025 Counter SHALL never wrap; its maximum reachable value is FILTER-1.

Reset
REQ-026 rst==1 at an edge SHALL force out, rise, fall, pend, ovf and all cnt to 0, overriding in and ack.
REQ-027 Reset mid-filter SHALL discard partial counts; after release, a level already 1 on in SHALL be accepted FILTER edges later and reported as rise.
REQ-028 out reset value 0 SHALL match the reset value of the upstream bistable crossing, so no spurious event follows joint reset.

Verification (WIDTH=2, FILTER=3)
REQ-029 in=2'b00 -> 2'b11 held: out=2'b11 on the 3rd edge after change; rise=2'b11 for exactly 1 cycle; pend=2'b11; irq=1.
REQ-030 in[0] high for 2 cycles then low: out, rise, pend unchanged (all 0); next high for 3 cycles accepted normally.
REQ-031 After REQ-029 without ack, in=2'b00 held 3 cycles: fall=2'b11 one cycle, ovf=2'b11, pend=2'b11; ack=2'b11 one cycle -> pend=ovf=0, irq=0.
REQ-032 ack[1] asserted on the exact edge channel 1 accepts a change: pend[1]=1, ovf[1]=0 afterwards.
REQ-033 rst pulsed while cnt[0]=2 with in[0]=1: all outputs 0 next cycle; out[0]=1 and rise[0]=1 appear 3 edges after rst release.
REQ-034 Random in/ack over 10000 cycles vs. reference model: out, rise, fall, pend, ovf match cycle-exactly; rise&fall always 0.

Source files
------------

// File: rtl/bistable_event_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : bistable_event_decoder
//  Description : Per-channel level filter and event decoder for level
//                signals already synchronized into the clk domain.
//                A level change is accepted once `in` has differed from
//                the accepted level for FILTER consecutive clock edges.
//                Each acceptance produces a one-cycle rise/fall pulse and
//                sets a sticky pending flag. If a channel accepts again
//                while its pending flag is still set, its overflow flag is
//                set. `irq` is the combinational OR of all pending flags.
//
//  Ports       : clk   - clock; all state updates on the rising edge
//                rst   - synchronous, active-high reset
//                in    - [WIDTH] synchronized level inputs
//                ack   - [WIDTH] per-channel acknowledge; clears pend/ovf
//                out   - [WIDTH] filtered, accepted levels
//                rise  - [WIDTH] one-cycle pulse on an accepted 0->1 change
//                fall  - [WIDTH] one-cycle pulse on an accepted 1->0 change
//                pend  - [WIDTH] sticky event-pending flags
//                ovf   - [WIDTH] sticky event-lost flags
//                irq   - OR of all pend bits
//
//  Revision    : 1.0 - initial release
// ============================================================================
module bistable_event_decoder #(
    parameter int WIDTH  = 2,
    parameter int FILTER = 3    // legal range 1..255
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in,
    input  logic [WIDTH-1:0] ack,
    output logic [WIDTH-1:0] out,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall,
    output logic [WIDTH-1:0] pend,
    output logic [WIDTH-1:0] ovf,
    output logic             irq
);

    // The counter only ever reaches FILTER-1 (it clears on acceptance), so
    // clog2(FILTER+1) bits always hold that value without wrapping.
    localparam int            CW         = $clog2(FILTER + 1);
    localparam logic [CW-1:0] C_CNT_MAX  = CW'(FILTER - 1);
    localparam logic [CW-1:0] C_CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] C_CNT_ZERO = '0;

    for (genvar i = 0; i < WIDTH; i++) begin : g_chan
        logic [CW-1:0] r_cnt;
        logic          r_out;
        logic          r_rise;
        logic          r_fall;
        logic          r_pend;
        logic          r_ovf;
        logic          w_diff;
        logic          w_accept;

        assign w_diff   = in[i] ^ r_out;
        // With FILTER=1 the maximum is 0, so the first differing edge accepts.
        assign w_accept = w_diff && (r_cnt == C_CNT_MAX);

        always_ff @(posedge clk) begin
            if (rst) begin
                r_cnt  <= C_CNT_ZERO;
                r_out  <= 1'b0;
                r_rise <= 1'b0;
                r_fall <= 1'b0;
                r_pend <= 1'b0;
                r_ovf  <= 1'b0;
            end else begin
                // Consecutive-difference counter: any agreeing edge restarts
                // the filter window, so glitches shorter than FILTER vanish.
                if (!w_diff || w_accept) begin
                    r_cnt <= C_CNT_ZERO;
                end else begin
                    r_cnt <= r_cnt + C_CNT_ONE;
                end

                if (w_accept) begin
                    r_out <= in[i];
                end

                r_rise <= w_accept &  in[i];
                r_fall <= w_accept & ~in[i];

                // A new acceptance wins over ack for pend, so an event that
                // lands on the acknowledging edge is not lost.
                r_pend <= w_accept | (r_pend & ~ack[i]);

                // ack always clears ovf; otherwise a second event arriving
                // while the first is still pending marks a lost event.
                if (ack[i]) begin
                    r_ovf <= 1'b0;
                end else if (w_accept && r_pend) begin
                    r_ovf <= 1'b1;
                end
            end
        end

        assign out[i]  = r_out;
        assign rise[i] = r_rise;
        assign fall[i] = r_fall;
        assign pend[i] = r_pend;
        assign ovf[i]  = r_ovf;
    end

    assign irq = |pend;

endmodule
`default_nettype wire
